instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 130 +++++++++++++
 tb/tb_instr_fetch.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC handshake in, instruction memory port, decoded instruction out.
// The fetch unit takes the master view; the surrounding pipeline/memory take the slave view.
interface instr_fetch_if;
   logic [31:0] pc;
   logic        pc_valid;
   logic        pc_ready;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        fetch_fault;
   logic        dec_ready;

   modport master (
      input  pc, pc_valid, flush, mem_rdata, mem_ack, dec_ready,
      output pc_ready, mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_fault
   );

   modport slave (
      output pc, pc_valid, flush, mem_rdata, mem_ack, dec_ready,
      input  pc_ready, mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_fault
   );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit with a 2-entry instruction buffer.
// Misaligned PCs bypass memory and enqueue a faulting NOP entry.
module instr_fetch (
   input logic           clk,
   input logic           rst,
   instr_fetch_if.master bus
);

   localparam logic [31:0] NopInstr = 32'h00000013;

   typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

   state_e      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [1:0]  count_q, count_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;

   logic [31:0] buf_instr_q [2];
   logic [31:0] buf_pc_q    [2];
   logic        buf_fault_q [2];

   logic        pc_ready;
   logic        accept;
   logic        aligned;
   logic        push;
   logic        pop;
   logic [31:0] push_instr;
   logic [31:0] push_pc;
   logic        push_fault;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      case (state_q)
         StIdle: begin
            if (accept && aligned) begin
               state_d    = StBusy;
               mem_req_d  = 1'b1;
               mem_addr_d = {bus.pc[31:2], 2'b00};
            end
         end
         StBusy: begin
            if (bus.mem_ack) begin
               state_d   = StIdle;
               mem_req_d = 1'b0;
            end else if (bus.flush) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            // The flushed request must still complete before a new one may issue.
            if (bus.mem_ack) begin
               state_d   = StIdle;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
         end
      endcase

      if (bus.flush) begin
         count_d  = '0;
         wr_ptr_d = rd_ptr_q;
         rd_ptr_d = rd_ptr_q;
      end else begin
         count_d  = count_q + {1'b0, push} - {1'b0, pop};
         wr_ptr_d = wr_ptr_q ^ push;
         rd_ptr_d = rd_ptr_q ^ pop;
      end
   end

   always_comb begin
      pc_ready   = (state_q == StIdle) && (count_q != 2'd2) && !bus.flush;
      accept     = bus.pc_valid && pc_ready;
      aligned    = (bus.pc[1:0] == 2'b00);
      push       = 1'b0;
      push_instr = NopInstr;
      push_pc    = bus.pc;
      push_fault = 1'b1;
      if ((state_q == StBusy) && bus.mem_ack && !bus.flush) begin
         push       = 1'b1;
         push_instr = bus.mem_rdata;
         push_pc    = mem_addr_q;
         push_fault = 1'b0;
      end else if (accept && !aligned) begin
         push = 1'b1;
      end
      pop = (count_q != 2'd0) && bus.dec_ready && !bus.flush;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr_q[wr_ptr_q] <= push_instr;
         buf_pc_q[wr_ptr_q]    <= push_pc;
         buf_fault_q[wr_ptr_q] <= push_fault;
      end
   end

   assign bus.pc_ready    = pc_ready;
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.instr       = buf_instr_q[rd_ptr_q];
   assign bus.instr_pc    = buf_pc_q[rd_ptr_q];
   assign bus.fetch_fault = buf_fault_q[rd_ptr_q];
   assign bus.instr_valid = (count_q != 2'd0);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic against a queue-based model.
module tb_instr_fetch;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } entry_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   // Reference model: FIFO contents, outstanding request, and whether its data is to be dropped.
   entry_t      q[$];
   bit          m_out  = 1'b0;
   bit          m_disc = 1'b0;
   logic [31:0] m_addr = '0;

   instr_fetch_if bus ();

   instr_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      bit     rdy;
      bit     acc;
      bit     do_pop;
      bit     have_push;
      entry_t e;
      rdy = !m_out && (q.size() < 2) && !bus.flush;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_out  = 1'b0;
         m_disc = 1'b0;
         m_addr = '0;
      end else begin
         acc       = bus.pc_valid && rdy;
         do_pop    = !bus.flush && (q.size() > 0) && bus.dec_ready;
         have_push = 1'b0;
         e         = '0;
         if (m_out && bus.mem_ack) begin
            if (!m_disc && !bus.flush) begin
               have_push = 1'b1;
               e.instr   = bus.mem_rdata;
               e.pc      = m_addr;
               e.fault   = 1'b0;
            end
            m_out  = 1'b0;
            m_disc = 1'b0;
         end else if (m_out && bus.flush) begin
            m_disc = 1'b1;
         end
         if (acc) begin
            if (bus.pc[1:0] == 2'b00) begin
               m_out  = 1'b1;
               m_addr = bus.pc;
            end else begin
               have_push = 1'b1;
               e.instr   = 32'h00000013;
               e.pc      = bus.pc;
               e.fault   = 1'b1;
            end
         end
         if (do_pop) void'(q.pop_front());
         if (have_push) q.push_back(e);
         if (bus.flush) q.delete();
      end
      #1;
   endtask

   task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
      bus.pc       = addr;
      bus.pc_valid = 1'b1;
      tick();
      bus.pc_valid  = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = data;
      tick();
      bus.mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++; if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL reset_pc_ready got %b exp 1", bus.pc_ready); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b exp 0", bus.instr_valid); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", bus.mem_req); end
      checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", bus.mem_addr); end
   endtask

   task automatic test_basic();
      bus.pc = 32'h100; bus.pc_valid = 1'b1; bus.dec_ready = 1'b1;
      #1;
      checks++; if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", bus.pc_ready); end
      tick();
      bus.pc_valid = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00500093;
      #1;
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL basic_mem_req got %b exp 1", bus.mem_req); end
      checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL basic_mem_addr got %h exp 100", bus.mem_addr); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", bus.instr_valid); end
      tick();
      bus.mem_ack = 1'b0;
      #1;
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", bus.instr_valid); end
      checks++; if (bus.instr !== 32'h00500093) begin errors++; $display("FAIL basic_instr got %h exp 00500093", bus.instr); end
      checks++; if (bus.instr_pc !== 32'h100) begin errors++; $display("FAIL basic_instr_pc got %h exp 100", bus.instr_pc); end
      checks++; if (bus.fetch_fault !== 1'b0) begin errors++; $display("FAIL basic_fault got %b exp 0", bus.fetch_fault); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop got %b exp 0", bus.mem_req); end
      tick();
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %b exp 0", bus.instr_valid); end
   endtask

   task automatic test_backpressure();
      bus.dec_ready = 1'b0;
      fetch_one(32'h0, 32'h00000111);
      fetch_one(32'h4, 32'h00000444);
      bus.pc = 32'h8; bus.pc_valid = 1'b1;
      #1;
      checks++; if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", bus.pc_ready); end
      tick();
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL bp_not_accepted got %b exp 0", bus.mem_req); end
      checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL bp_head0 got %h exp 0", bus.instr_pc); end
      bus.dec_ready = 1'b1;
      tick();
      bus.dec_ready = 1'b0;
      #1;
      checks++; if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b exp 1", bus.pc_ready); end
      checks++; if (bus.instr_pc !== 32'h4) begin errors++; $display("FAIL bp_head1 got %h exp 4", bus.instr_pc); end
      tick();
      bus.pc_valid = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00000888;
      #1;
      checks++; if (bus.mem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr8 got %h exp 8", bus.mem_addr); end
      tick();
      bus.mem_ack = 1'b0; bus.dec_ready = 1'b1;
      #1;
      checks++; if (bus.instr !== 32'h00000444) begin errors++; $display("FAIL bp_instr1 got %h exp 444", bus.instr); end
      tick();
      checks++; if (bus.instr_pc !== 32'h8) begin errors++; $display("FAIL bp_head2 got %h exp 8", bus.instr_pc); end
      checks++; if (bus.instr !== 32'h00000888) begin errors++; $display("FAIL bp_instr2 got %h exp 888", bus.instr); end
      tick();
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", bus.instr_valid); end
      bus.dec_ready = 1'b0;
   endtask

   task automatic test_misaligned();
      bus.pc = 32'h102; bus.pc_valid = 1'b1;
      tick();
      bus.pc_valid = 1'b0;
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mis_mem_req got %b exp 0", bus.mem_req); end
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL mis_valid got %b exp 1", bus.instr_valid); end
      checks++; if (bus.fetch_fault !== 1'b1) begin errors++; $display("FAIL mis_fault got %b exp 1", bus.fetch_fault); end
      checks++; if (bus.instr !== 32'h00000013) begin errors++; $display("FAIL mis_instr got %h exp 00000013", bus.instr); end
      checks++; if (bus.instr_pc !== 32'h102) begin errors++; $display("FAIL mis_pc got %h exp 102", bus.instr_pc); end
      bus.dec_ready = 1'b1;
      tick();
      bus.dec_ready = 1'b0;
   endtask

   task automatic test_flush_in_flight();
      bus.pc = 32'h40; bus.pc_valid = 1'b1; bus.dec_ready = 1'b1;
      tick();
      bus.pc_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      #1;
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL flush_drain_req got %b exp 1", bus.mem_req); end
      checks++; if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL flush_drain_ready got %b exp 0", bus.pc_ready); end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      #1;
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL flush_redrain_req got %b exp 1", bus.mem_req); end
      checks++; if (bus.pc_ready !== 1'b0) begin errors++; $display("FAIL flush_redrain_ready got %b exp 0", bus.pc_ready); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
      tick();
      bus.mem_ack = 1'b0;
      #1;
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL flush_no_data got %b exp 0", bus.instr_valid); end
      checks++; if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_back got %b exp 1", bus.pc_ready); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL flush_req_drop got %b exp 0", bus.mem_req); end
      bus.dec_ready = 1'b0;
   endtask

   task automatic test_wait_states();
      bus.pc = 32'h200; bus.pc_valid = 1'b1;
      tick();
      bus.pc_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.mem_ack   = (i == 5);
         bus.mem_rdata = 32'h00A00513;
         #1;
         checks++;
         if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin
            errors++;
            $display("FAIL wait_stable cyc %0d got req %b addr %h exp req 1 addr 200", i, bus.mem_req, bus.mem_addr);
         end
         tick();
      end
      bus.mem_ack = 1'b0;
      #1;
      checks++; if (bus.instr !== 32'h00A00513) begin errors++; $display("FAIL wait_instr got %h exp 00a00513", bus.instr); end
      bus.dec_ready = 1'b1;
      tick();
      bus.dec_ready = 1'b0;
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL wait_one_push got %b exp 0", bus.instr_valid); end
   endtask

   task automatic test_reset_mid_request();
      fetch_one(32'h10, 32'h00100093);
      bus.pc = 32'h14; bus.pc_valid = 1'b1;
      tick();
      bus.pc_valid = 1'b0;
      #1;
      checks++; if (bus.mem_req !== 1'b1 || bus.instr_valid !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre got req %b valid %b exp 1 1", bus.mem_req, bus.instr_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %b exp 0", bus.mem_req); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", bus.instr_valid); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
      tick();
      bus.mem_ack = 1'b0;
      #1;
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_late_ack got %b exp 0", bus.instr_valid); end
      checks++; if (bus.pc_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", bus.pc_ready); end
   endtask

   task automatic test_random();
      logic [31:0] pcv;
      bit          exp_ready;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 63) == 0);
         bus.flush     = ($urandom_range(0, 15) == 0);
         bus.pc_valid  = $urandom_range(0, 1);
         pcv           = {22'h0, 10'($urandom)};
         if ($urandom_range(0, 3) != 0) pcv[1:0] = 2'b00;
         bus.pc        = pcv;
         bus.mem_ack   = ($urandom_range(0, 2) == 0);
         bus.mem_rdata = $urandom;
         bus.dec_ready = $urandom_range(0, 1);
         #1;
         exp_ready = !m_out && (q.size() < 2) && !bus.flush;
         checks++; if (bus.pc_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, bus.pc_ready, exp_ready); end
         checks++; if (bus.mem_req !== m_out) begin errors++; $display("FAIL rnd_mem_req cyc %0d got %b exp %b", i, bus.mem_req, m_out); end
         checks++; if (bus.mem_addr !== m_addr) begin errors++; $display("FAIL rnd_mem_addr cyc %0d got %h exp %h", i, bus.mem_addr, m_addr); end
         checks++; if (bus.instr_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, bus.instr_valid, q.size() > 0); end
         if (q.size() > 0) begin
            checks++;
            if (bus.instr !== q[0].instr || bus.instr_pc !== q[0].pc || bus.fetch_fault !== q[0].fault) begin
               errors++;
               $display("FAIL rnd_head cyc %0d got %h/%h/%b exp %h/%h/%b", i, bus.instr, bus.instr_pc,
                        bus.fetch_fault, q[0].instr, q[0].pc, q[0].fault);
            end
         end
         tick();
      end
      rst = 1'b0; bus.flush = 1'b0; bus.pc_valid = 1'b0; bus.mem_ack = 1'b0; bus.dec_ready = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.pc        = '0;
      bus.pc_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.mem_rdata = '0;
      bus.mem_ack   = 1'b0;
      bus.dec_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_misaligned();
      test_flush_in_flight();
      test_wait_states();
      test_reset_mid_request();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
